// File: rtl/multiplexer_32bit_2x1_pkg.sv
// Shared defaults for the 32-bit 2:1 multiplexer slice.
package multiplexer_32bit_2x1_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT  = 16;

endpackage : multiplexer_32bit_2x1_pkg

// File: rtl/multiplexer_32bit_2x1_mux2_core.sv
// Pure combinational 2:1 selector; an unknown select propagates X to y.
module mux2_core
  import multiplexer_32bit_2x1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] y
);

  // Case form so an X/Z select yields all-X rather than a merged ternary result.
  always_comb begin
    y = 'x;
    case (sel)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end

endmodule : mux2_core

// File: rtl/multiplexer_32bit_2x1.sv
// 2:1 data mux with registered output, parity, select-change pulse and a
// saturating select-toggle counter.
module multiplexer_32bit_2x1
  import multiplexer_32bit_2x1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] input1,
  input  logic [DATA_W-1:0] input2,
  input  logic              select,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] out_q,
  output logic              out_parity,
  output logic              sel_q,
  output logic              sel_changed,
  output logic [CNT_W-1:0]  toggle_cnt
);

  mux2_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .a   (input1),
    .b   (input2),
    .sel (select),
    .y   (out)
  );

  // Odd parity of the registered data; stays consistent with out_q at all times.
  always_comb begin
    out_parity = ^out_q;
  end

  // Output/select registers and the change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      sel_q       <= 1'b0;
      sel_changed <= 1'b0;
    end else begin
      out_q       <= out;
      sel_q       <= select;
      sel_changed <= select ^ sel_q;
    end
  end

  // Counts select changes; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
    end else if ((select != sel_q) && (toggle_cnt != '1)) begin
      toggle_cnt <= toggle_cnt + CNT_W'(1);
    end
  end

endmodule : multiplexer_32bit_2x1

// File: tb/tb_multiplexer_32bit_2x1.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor
// compares them one cycle later against the registered outputs.
module tb_multiplexer_32bit_2x1;

  logic        clk;
  logic        rst_n;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        select;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        out_parity;
  logic        sel_q;
  logic        sel_changed;
  logic [15:0] toggle_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [31:0] out_e;
    logic [31:0] outq_e;
    logic        par_e;
    logic        selq_e;
    logic        chg_e;
    logic [15:0] cnt_e;
  } exp_t;

  exp_t q[$];

  multiplexer_32bit_2x1 #(
    .DATA_W(32),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input1     (input1),
    .input2     (input2),
    .select     (select),
    .out        (out),
    .out_q      (out_q),
    .out_parity (out_parity),
    .sel_q      (sel_q),
    .sel_changed(sel_changed),
    .toggle_cnt (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%08h expected=0x%08h", nm, id, act, exp);
    end
  endtask

  // Drive one vector at the current negedge, queue its expectations, advance a cycle.
  task automatic step(input int id, input logic [31:0] i1, input logic [31:0] i2, input logic s,
                      input logic [31:0] oe, input logic [31:0] oqe, input logic pe,
                      input logic sqe, input logic ce, input logic [15:0] cne);
    exp_t e;
    input1 = i1;
    input2 = i2;
    select = s;
    e.id = id; e.out_e = oe; e.outq_e = oqe; e.par_e = pe;
    e.selq_e = sqe; e.chg_e = ce; e.cnt_e = cne;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every cycle is valid, so compare one queued entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out",         e.id, out,                  e.out_e);
        chk("out_q",       e.id, out_q,                e.outq_e);
        chk("out_parity",  e.id, {31'b0, out_parity},  {31'b0, e.par_e});
        chk("sel_q",       e.id, {31'b0, sel_q},       {31'b0, e.selq_e});
        chk("sel_changed", e.id, {31'b0, sel_changed}, {31'b0, e.chg_e});
        chk("toggle_cnt",  e.id, {16'b0, toggle_cnt},  {16'b0, e.cnt_e});
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int spins;
    rst_n  = 1'b0;
    input1 = 32'h703AD331;
    input2 = 32'hAF722DBA;
    select = 1'b0;
    #1;
    // Reset state, combinational path live during reset
    chk("rst_out",    0, out,                  32'h703AD331);
    chk("rst_out_q",  0, out_q,                32'h0);
    chk("rst_par",    0, {31'b0, out_parity},  32'h0);
    chk("rst_sel_q",  0, {31'b0, sel_q},       32'h0);
    chk("rst_chg",    0, {31'b0, sel_changed}, 32'h0);
    chk("rst_cnt",    0, {16'b0, toggle_cnt},  32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    //    id  input1        input2        sel  out           out_q         par  selq chg  cnt
    step(1,  32'h703AD331, 32'hAF722DBA, 0, 32'h703AD331, 32'h703AD331, 1, 0, 0, 16'd0);
    step(2,  32'h703AD331, 32'hAF722DBA, 1, 32'hAF722DBA, 32'hAF722DBA, 1, 1, 1, 16'd1);
    step(3,  32'h703AD331, 32'hAF722DBA, 1, 32'hAF722DBA, 32'hAF722DBA, 1, 1, 0, 16'd1);
    step(4,  32'h703AD331, 32'hAF722DBA, 0, 32'h703AD331, 32'h703AD331, 1, 0, 1, 16'd2);
    step(5,  32'h703AD331, 32'hAF722DBA, 0, 32'h703AD331, 32'h703AD331, 1, 0, 0, 16'd2);
    step(6,  32'h703AD331, 32'hAF722DBA, 1, 32'hAF722DBA, 32'hAF722DBA, 1, 1, 1, 16'd3);
    step(7,  32'h703AD331, 32'hAF722DBA, 0, 32'h703AD331, 32'h703AD331, 1, 0, 1, 16'd4);
    step(8,  32'h703AD331, 32'hAF722DBA, 1, 32'hAF722DBA, 32'hAF722DBA, 1, 1, 1, 16'd5);

    // Asynchronous reset mid-cycle with toggle_cnt=5
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_q", 8, out_q,                32'h0);
    chk("arst_sel_q", 8, {31'b0, sel_q},       32'h0);
    chk("arst_chg",   8, {31'b0, sel_changed}, 32'h0);
    chk("arst_cnt",   8, {16'b0, toggle_cnt},  32'h0);
    chk("arst_par",   8, {31'b0, out_parity},  32'h0);
    chk("arst_out1",  8, out,                  32'hAF722DBA);
    select = 1'b0;
    #1;
    chk("arst_out0",  8, out,                  32'h703AD331);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset: select=1 counts as a change; inputs and select change together
    step(9,  32'h00000000, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1, 16'd1);
    step(10, 32'h00000000, 32'hFFFFFFFF, 0, 32'h00000000, 32'h00000000, 0, 0, 1, 16'd2);
    step(11, 32'h00000000, 32'hFFFFFFFF, 0, 32'h00000000, 32'h00000000, 0, 0, 0, 16'd2);

    // Saturation: preload counter near the top
    force dut.toggle_cnt = 16'hFFFE;
    #1;
    release dut.toggle_cnt;
    step(12, 32'h00000000, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1, 16'hFFFF);
    step(13, 32'h00000000, 32'hFFFFFFFF, 0, 32'h00000000, 32'h00000000, 0, 0, 1, 16'hFFFF);
    step(14, 32'h00000000, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1, 16'hFFFF);
    step(15, 32'h00000000, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 16'hFFFF);
    step(16, 32'h12345678, 32'h00000000, 0, 32'h12345678, 32'h12345678, 1, 0, 1, 16'hFFFF);

    spins = 0;
    while (q.size() != 0 && spins < 5) begin
      @(negedge clk);
      spins++;
    end
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_multiplexer_32bit_2x1
